// File: rtl/bus_mux_sched_pkg.sv
// Shared definitions for the bus_mux time-slot scheduler: FSM encoding,
// default mux pipeline depth and a width helper.
package bus_mux_sched_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam int DEFAULT_MUX_LATENCY = 3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/bus_mux_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the lowest index at or above the pointer
// wins, otherwise the lowest index below it (wrapping search order).
module bus_mux_sched_rr_arbiter #(
    parameter int NUM_INPUT = 8,
    parameter int SEL_BIT   = 3
) (
    input  logic [NUM_INPUT-1:0] req_i,
    input  logic [SEL_BIT-1:0]   ptr_i,
    output logic [NUM_INPUT-1:0] grant_o,
    output logic [SEL_BIT-1:0]   idx_o,
    output logic                 any_o
);

    logic                 hiFound;
    logic                 loFound;
    logic [SEL_BIT-1:0]   hiIdx;
    logic [SEL_BIT-1:0]   loIdx;

    // Descending scans so the last hit written is the lowest index in each half.
    always_comb begin
        hiFound = 1'b0;
        loFound = 1'b0;
        hiIdx   = '0;
        loIdx   = '0;
        for (int i = NUM_INPUT - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                if (i >= int'(ptr_i)) begin
                    hiFound = 1'b1;
                    hiIdx   = SEL_BIT'(i);
                end else begin
                    loFound = 1'b1;
                    loIdx   = SEL_BIT'(i);
                end
            end
        end
    end

    always_comb begin
        any_o   = hiFound | loFound;
        idx_o   = hiFound ? hiIdx : loIdx;
        grant_o = any_o ? (NUM_INPUT'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/bus_mux_sched.sv
// Round-robin time-slot scheduler driving a bus_mux select, with a valid/source
// tag delayed to line up with data leaving the mux pipeline.
module bus_mux_sched
    import bus_mux_sched_pkg::*;
#(
    parameter int NUM_INPUT   = 8,
    parameter int SEL_BIT     = 3,
    parameter int DWELL_BIT   = 4,
    parameter int MUX_LATENCY = DEFAULT_MUX_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic [NUM_INPUT-1:0] req_i,
    input  logic [DWELL_BIT-1:0] dwell_i,
    output logic [SEL_BIT-1:0]   sel_o,
    output logic [NUM_INPUT-1:0] grant_o,
    output logic                 busy_o,
    output logic                 out_valid_o,
    output logic [SEL_BIT-1:0]   out_src_o
);

    state_e                 state_q;
    logic [SEL_BIT-1:0]     sel_q;
    logic [NUM_INPUT-1:0]   grant_q;
    logic                   busy_q;
    logic [SEL_BIT-1:0]     ptr_q;
    logic [DWELL_BIT-1:0]   cnt_q;
    logic [DWELL_BIT-1:0]   len_q;
    logic [MUX_LATENCY-1:0] validPipe_q;
    logic [SEL_BIT-1:0]     srcPipe_q [MUX_LATENCY];

    logic [SEL_BIT-1:0]     nextPtr_d;
    logic [SEL_BIT-1:0]     arbPtr;
    logic [NUM_INPUT-1:0]   arbGrant;
    logic [SEL_BIT-1:0]     arbIdx;
    logic                   arbAny;
    logic [DWELL_BIT-1:0]   dwellLen;
    logic                   ownerReq;
    logic                   slotEnd;

    // While holding, arbitrate from owner+1 so a slot ending can hand over on the same edge.
    always_comb begin
        nextPtr_d = (sel_q == SEL_BIT'(NUM_INPUT - 1)) ? '0 : sel_q + 1'b1;
        arbPtr    = (state_q == ST_HOLD) ? nextPtr_d : ptr_q;
        dwellLen  = (dwell_i == '0) ? DWELL_BIT'(1) : dwell_i;
        ownerReq  = |(grant_q & req_i);
        slotEnd   = (cnt_q == len_q - 1'b1) || !ownerReq;
    end

    bus_mux_sched_rr_arbiter #(
        .NUM_INPUT (NUM_INPUT),
        .SEL_BIT   (SEL_BIT)
    ) u_arbiter (
        .req_i   (req_i),
        .ptr_i   (arbPtr),
        .grant_o (arbGrant),
        .idx_o   (arbIdx),
        .any_o   (arbAny)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable_i && arbAny) begin
                        state_q <= ST_HOLD;
                        grant_q <= arbGrant;
                        sel_q   <= arbIdx;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        len_q   <= dwellLen;
                    end
                end
                ST_HOLD: begin
                    if (slotEnd) begin
                        ptr_q <= nextPtr_d;
                        if (enable_i && arbAny) begin
                            grant_q <= arbGrant;
                            sel_q   <= arbIdx;
                            cnt_q   <= '0;
                            len_q   <= dwellLen;
                        end else begin
                            state_q <= ST_IDLE;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Tag travels alongside the data through the mux pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validPipe_q <= '0;
            for (int i = 0; i < MUX_LATENCY; i++) begin
                srcPipe_q[i] <= '0;
            end
        end else begin
            validPipe_q[0] <= ownerReq;
            srcPipe_q[0]   <= sel_q;
            for (int i = 1; i < MUX_LATENCY; i++) begin
                validPipe_q[i] <= validPipe_q[i-1];
                srcPipe_q[i]   <= srcPipe_q[i-1];
            end
        end
    end

    assign sel_o       = sel_q;
    assign grant_o     = grant_q;
    assign busy_o      = busy_q;
    assign out_valid_o = validPipe_q[MUX_LATENCY-1];
    assign out_src_o   = srcPipe_q[MUX_LATENCY-1];

endmodule

// File: tb/tb_bus_mux_sched.sv
// Directed bench for bus_mux_sched: an 8-input default instance plus a 5-input
// instance for the non-power-of-two wrap case.
module tb_bus_mux_sched;

    logic       clk;
    logic       rst;

    logic       en8;
    logic [7:0] req8;
    logic [3:0] dwell8;
    logic [2:0] sel8;
    logic [7:0] grant8;
    logic       busy8;
    logic       ov8;
    logic [2:0] src8;

    logic       en5;
    logic [4:0] req5;
    logic [3:0] dwell5;
    logic [2:0] sel5;
    logic [4:0] grant5;
    logic       busy5;
    logic       ov5;
    logic [2:0] src5;

    int vectorCount = 0;
    int missCount   = 0;

    bus_mux_sched dut8 (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (en8),
        .req_i       (req8),
        .dwell_i     (dwell8),
        .sel_o       (sel8),
        .grant_o     (grant8),
        .busy_o      (busy8),
        .out_valid_o (ov8),
        .out_src_o   (src8)
    );

    bus_mux_sched #(
        .NUM_INPUT   (5),
        .SEL_BIT     (3),
        .DWELL_BIT   (4),
        .MUX_LATENCY (3)
    ) dut5 (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (en5),
        .req_i       (req5),
        .dwell_i     (dwell5),
        .sel_o       (sel5),
        .grant_o     (grant5),
        .busy_o      (busy5),
        .out_valid_o (ov5),
        .out_src_o   (src5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] req, input logic [3:0] dwell, input logic en);
        req8   = req;
        dwell8 = dwell;
        en8    = en;
    endtask

    // Leaves the bench on a falling edge with reset just released and inputs idle.
    task automatic startTest();
        @(negedge clk);
        rst  = 1'b1;
        req8 = '0;
        req5 = '0;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
    endtask

    logic [7:0] fairOrder [4];
    logic [7:0] dwellZeroOrder [4];
    logic [2:0] wrapSel [4];
    logic [4:0] wrapGrant [4];

    initial begin
        fairOrder      = '{8'h01, 8'h10, 8'h80, 8'h01};
        dwellZeroOrder = '{8'h01, 8'h02, 8'h01, 8'h02};
        wrapSel        = '{3'd0, 3'd4, 3'd0, 3'd4};
        wrapGrant      = '{5'h01, 5'h10, 5'h01, 5'h10};

        rst    = 1'b1;
        en5    = 1'b1;
        req5   = '0;
        dwell5 = 4'd1;
        applyStimulus(8'hFF, 4'd3, 1'b1);

        $display("[TB] reset holds outputs low");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("rst_grant", 32'(grant8), 0);
            checkOutput("rst_busy", 32'(busy8), 0);
            checkOutput("rst_valid", 32'(ov8), 0);
            checkOutput("rst_sel", 32'(sel8), 0);
        end

        $display("[TB] single requester back-to-back");
        startTest();
        applyStimulus(8'h04, 4'd3, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checkOutput("single_grant", 32'(grant8), 32'h04);
            checkOutput("single_sel", 32'(sel8), 2);
            checkOutput("single_busy", 32'(busy8), 1);
            checkOutput("single_valid", 32'(ov8), (k >= 4) ? 1 : 0);
            if (k >= 4) checkOutput("single_src", 32'(src8), 2);
        end

        $display("[TB] fairness across 0,4,7");
        startTest();
        applyStimulus(8'h91, 4'd2, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("fair_grant", 32'(grant8), 32'(fairOrder[k/2]));
        end

        $display("[TB] early release");
        startTest();
        applyStimulus(8'h28, 4'd8, 1'b1);
        @(negedge clk);
        checkOutput("early_grant1", 32'(grant8), 32'h08);
        @(negedge clk);
        checkOutput("early_grant2", 32'(grant8), 32'h08);
        applyStimulus(8'h20, 4'd8, 1'b1);
        @(negedge clk);
        checkOutput("early_grant3", 32'(grant8), 32'h20);
        checkOutput("early_sel3", 32'(sel8), 5);
        @(negedge clk);
        checkOutput("early_valid4", 32'(ov8), 1);
        checkOutput("early_src4", 32'(src8), 3);
        @(negedge clk);
        checkOutput("early_valid5", 32'(ov8), 0);
        @(negedge clk);
        checkOutput("early_valid6", 32'(ov8), 1);
        checkOutput("early_src6", 32'(src8), 5);

        $display("[TB] enable low mid-slot then resume");
        startTest();
        applyStimulus(8'h06, 4'd5, 1'b1);
        @(negedge clk);
        checkOutput("en_grant1", 32'(grant8), 32'h02);
        @(negedge clk);
        applyStimulus(8'h06, 4'd5, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("en_grant5", 32'(grant8), 32'h02);
        checkOutput("en_busy5", 32'(busy8), 1);
        @(negedge clk);
        checkOutput("en_grant6", 32'(grant8), 0);
        checkOutput("en_busy6", 32'(busy8), 0);
        checkOutput("en_sel6", 32'(sel8), 1);
        @(negedge clk);
        checkOutput("en_grant7", 32'(grant8), 0);
        applyStimulus(8'h06, 4'd5, 1'b1);
        @(negedge clk);
        checkOutput("en_grant8", 32'(grant8), 32'h04);
        checkOutput("en_sel8", 32'(sel8), 2);

        $display("[TB] dwell zero, 5-input wrap, async reset");
        startTest();
        applyStimulus(8'h03, 4'd0, 1'b1);
        req5   = 5'h11;
        dwell5 = 4'd1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("dz_grant", 32'(grant8), 32'(dwellZeroOrder[k]));
            checkOutput("wrap_sel", 32'(sel5), 32'(wrapSel[k]));
            checkOutput("wrap_grant", 32'(grant5), 32'(wrapGrant[k]));
        end
        checkOutput("dz_valid", 32'(ov8), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_grant", 32'(grant8), 0);
        checkOutput("arst_busy", 32'(busy8), 0);
        checkOutput("arst_valid", 32'(ov8), 0);
        checkOutput("arst_sel", 32'(sel8), 0);
        checkOutput("arst_src", 32'(src8), 0);
        checkOutput("arst_grant5", 32'(grant5), 0);
        checkOutput("arst_sel5", 32'(sel5), 0);
        checkOutput("arst_busy5", 32'(busy5), 0);
        @(negedge clk);
        rst = 1'b0;
        req8 = '0;
        req5 = '0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
